// File: rtl/control_unit_pkg.sv
// Shared opcode map, flag indices and FSM state type for the control unit.
// Built with or without CU_MEM_WAIT_EN (memory wait states).
package control_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_OP,
        FETCH_OPER,
        READ_MEM,
        EXEC,
        STORE,
        HALT
    } cu_state_t;

    localparam int CARRY = 0;
    localparam int OV    = 1;
    localparam int ZERO  = 2;
    localparam int NEG   = 3;

    localparam int   ALU_OPER2_BIT = 0;
    localparam int   MOV_OPER2_BIT = 0;
    localparam logic OPER2_X       = 1'b1;

    // Low opcode bit selects immediate (0) or memory (1) operand.
    localparam logic [7:0] OP_LOAD_I  = 8'h10;
    localparam logic [7:0] OP_LOAD_X  = 8'h11;
    localparam logic [7:0] OP_ADD_I   = 8'h20;
    localparam logic [7:0] OP_ADD_X   = 8'h21;
    localparam logic [7:0] OP_SUB_I   = 8'h22;
    localparam logic [7:0] OP_SUB_X   = 8'h23;
    localparam logic [7:0] OP_AND_I   = 8'h24;
    localparam logic [7:0] OP_AND_X   = 8'h25;
    localparam logic [7:0] OP_OR_I    = 8'h26;
    localparam logic [7:0] OP_OR_X    = 8'h27;
    localparam logic [7:0] OP_XOR_I   = 8'h28;
    localparam logic [7:0] OP_XOR_X   = 8'h29;
    localparam logic [7:0] OP_STORE_X = 8'h31;
    localparam logic [7:0] OP_JMP     = 8'h40;
    localparam logic [7:0] OP_JZ      = 8'h41;
    localparam logic [7:0] OP_JC      = 8'h42;
    localparam logic [7:0] OP_JN      = 8'h43;
    localparam logic [7:0] OP_JV      = 8'h44;
    localparam logic [7:0] OP_HALT    = 8'hFE;
    localparam logic [7:0] OP_NOP     = 8'hFF;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classification and jump condition evaluation.
// Undefined opcodes classify as nothing and behave like NOP.
module cu_decode
    import control_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op,
    input  logic [3:0]       flags,
    output logic             is_alu_x,
    output logic             is_alu_i,
    output logic             is_store,
    output logic             is_halt,
    output logic             is_jump,
    output logic             jump_taken
);

    logic [7:0] opc;
    logic       alu_grp;
    logic       mov_grp;

    assign opc     = op[7:0];
    assign alu_grp = (opc[7:4] == 4'h2) && (opc[3:1] <= 3'd4);
    assign mov_grp = (opc[7:1] == OP_LOAD_I[7:1]);

    always_comb begin
        is_alu_x = 1'b0;
        is_alu_i = 1'b0;
        is_store = 1'b0;
        is_halt  = 1'b0;
        unique case (1'b1)
            alu_grp: begin
                is_alu_x = (opc[ALU_OPER2_BIT] == OPER2_X);
                is_alu_i = (opc[ALU_OPER2_BIT] != OPER2_X);
            end
            mov_grp: begin
                is_alu_x = (opc[MOV_OPER2_BIT] == OPER2_X);
                is_alu_i = (opc[MOV_OPER2_BIT] != OPER2_X);
            end
            (opc == OP_STORE_X): is_store = 1'b1;
            (opc == OP_HALT):    is_halt  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        is_jump    = 1'b1;
        jump_taken = 1'b0;
        unique case (opc)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = flags[ZERO];
            OP_JC:   jump_taken = flags[CARRY];
            OP_JN:   jump_taken = flags[NEG];
            OP_JV:   jump_taken = flags[OV];
            default: is_jump    = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Two-byte instruction sequencer driving a unified program/data memory.
// Define CU_MEM_WAIT_EN to stall memory states until mem_ready.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ready,
    input  logic [WIDTH-1:0]      AR,
    input  logic [3:0]            Flags,
    output logic [WIDTH-1:0]      IR,
    output logic [WIDTH-1:0]      IBR,
    output logic [WIDTH-1:0]      MBR,
    output logic                  Exec,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  halted
);

    cu_state_t             state;
    cu_state_t             nxt;
    logic                  adv;
    logic                  is_alu_x;
    logic                  is_alu_i;
    logic                  is_store;
    logic                  is_halt;
    logic                  is_jump;
    logic                  jump_taken;
    logic [ADDR_WIDTH-1:0] ibr_addr;
    logic [ADDR_WIDTH-1:0] jmp_tgt;
    logic [ADDR_WIDTH-1:0] pc_inc;

`ifdef CU_MEM_WAIT_EN
    assign adv = mem_ready;
`else
    logic unused_ready;
    assign adv          = 1'b1;
    assign unused_ready = mem_ready;
`endif

    assign ibr_addr  = ADDR_WIDTH'(IBR);
    assign jmp_tgt   = ADDR_WIDTH'(mem_rdata);
    assign pc_inc    = PC + ADDR_WIDTH'(1);
    assign mem_wdata = AR;

    cu_decode #(.WIDTH(WIDTH)) u_decode (
        .op         (IR),
        .flags      (Flags),
        .is_alu_x   (is_alu_x),
        .is_alu_i   (is_alu_i),
        .is_store   (is_store),
        .is_halt    (is_halt),
        .is_jump    (is_jump),
        .jump_taken (jump_taken)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     nxt = FETCH_OP;
            FETCH_OP: if (adv) nxt = FETCH_OPER;
            FETCH_OPER: begin
                if (adv) begin
                    if (is_alu_x)      nxt = READ_MEM;
                    else if (is_alu_i) nxt = EXEC;
                    else if (is_store) nxt = STORE;
                    else if (is_halt)  nxt = HALT;
                    else               nxt = FETCH_OP;
                end
            end
            READ_MEM: if (adv) nxt = EXEC;
            EXEC:     nxt = FETCH_OP;
            STORE:    if (adv) nxt = FETCH_OP;
            HALT:     nxt = HALT;
            default:  nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        Exec     = 1'b0;
        halted   = 1'b0;
        mem_addr = PC;
        unique case (state)
            FETCH_OP, FETCH_OPER: mem_rd = 1'b1;
            READ_MEM: begin
                mem_rd   = 1'b1;
                mem_addr = ibr_addr;
            end
            STORE: begin
                mem_wr   = 1'b1;
                mem_addr = ibr_addr;
            end
            EXEC:    Exec   = 1'b1;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // Registers only move on a completed memory access.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            PC  <= '0;
            IR  <= '0;
            IBR <= '0;
            MBR <= '0;
        end else if (adv) begin
            case (state)
                FETCH_OP: begin
                    IR <= mem_rdata;
                    PC <= pc_inc;
                end
                FETCH_OPER: begin
                    IBR <= mem_rdata;
                    PC  <= (is_jump && jump_taken) ? jmp_tgt : pc_inc;
                end
                READ_MEM: MBR <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule
